clip_controller: RTL and testbench
==================================

Name: clip_controller

Overview:
- Record/playback sequencer for the four-clip audio recorder.
- Consumes the synchronized record/play buttons and the two clip-select switches (post-synchronizer levels).
- Drives the shared sample memory through a write port (record) and a read port (play); each clip owns one fixed memory region.
- Tracks per-clip recorded length, so playback stops at the end of the recorded material.

Parameters:
- OFFSET_W, 16, address bits per clip region; each clip holds 2^OFFSET_W samples.
- DATA_W, 8, sample width.

Ports:
- clock  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset; 0 forces the reset state immediately.
- record  in  1  synchronized record button level.
- play  in  1  synchronized play button level.
- clip_sel  in  2  {switch1, switch0}; selects clip 0-3.
- sample_tick  in  1  one-cycle strobe at the audio sample rate.
- sample_in  in  DATA_W  microphone sample; valid when sample_tick=1.
- mem_addr  out  OFFSET_W+2  {active_clip, offset}.
- mem_we  out  1  write strobe, one cycle.
- mem_wdata  out  DATA_W  write data.
- mem_re  out  1  read strobe, one cycle.
- mem_rdata  in  DATA_W  synchronous memory read data; valid the cycle after mem_re.
- audio_out  out  DATA_W  playback sample.
- recording  out  1  high in RECORD.
- playing  out  1  high in PLAY.

Behaviour:
- Reset (reset=0):
  - State IDLE; offset=0; active_clip=0.
  - All four length registers = 0. Length registers are OFFSET_W+1 bits wide.
  - Outputs mem_addr=0, mem_we=0, mem_wdata=0, mem_re=0, audio_out=0, recording=0, playing=0.
  - Edge-detect registers = 0.
- Edge detect:
  - rec_rise = record & ~record_q; play_rise = play & ~play_q.
  - Only rising edges act; held levels are ignored.
- All outputs are registered.
- IDLE:
  - rec_rise: latch clip_sel into active_clip; clear length[clip_sel]; offset=0; go to RECORD.
  - Else play_rise with length[clip_sel]!=0: latch clip_sel; offset=0; go to PLAY.
  - play_rise on an empty clip: no action; stay IDLE.
  - rec_rise and play_rise in the same cycle: record wins.
- RECORD:
  - sample_tick with no rec_rise:
    - Next cycle: mem_we=1, mem_addr={active_clip, offset}, mem_wdata=sample_in.
    - offset increments; length[active_clip] = offset+1.
  - Region full: after the write at offset 2^OFFSET_W-1, go to IDLE with length = 2^OFFSET_W. No wrap-around.
  - rec_rise: go to IDLE immediately; length keeps the samples already written.
  - rec_rise and sample_tick in the same cycle: stop wins; no write.
  - play_rise and clip_sel changes are ignored.
- PLAY:
  - sample_tick with no play_rise:
    - Next cycle: mem_re=1, mem_addr={active_clip, offset}.
    - offset increments.
  - End of clip: after the read at offset length-1, go to IDLE.
  - play_rise: go to IDLE; no further reads are issued.
  - play_rise and sample_tick in the same cycle: stop wins.
  - rec_rise and clip_sel changes are ignored.
- Read pipeline and audio_out:
  - audio_out captures mem_rdata on the clock edge one cycle after mem_re=1. It therefore changes 2 edges after the edge that raised mem_re.
  - A read already issued completes even if the state has returned to IDLE.
  - audio_out holds its last value otherwise; only reset clears it.
- recording = (state==RECORD); playing = (state==PLAY).
- Re-recording a clip overwrites it from offset 0. Lengths of the other clips are untouched.
- Reset asserted mid-RECORD or mid-PLAY:
  - Immediate return to the reset state; mem_we and mem_re drop asynchronously.
  - All lengths are cleared.

Test Plan:
1. Reset, then play_rise on any clip → stays IDLE; mem_re never asserts; playing=0.
2. OFFSET_W=4, clip_sel=2, rec_rise, 5 sample_ticks with sample_in=0x11..0x15, then rec_rise → mem_we pulses at addresses 0x20-0x24 with data 0x11-0x15; length[2]=5; recording falls.
3. Play clip 2 with 6 ticks → mem_re at 0x20-0x24 only (5 reads); audio_out=0x11..0x15 each 2 cycles after its mem_re; returns to IDLE after the 5th read.
4. OFFSET_W=4, record clip 1 with 20 ticks → exactly 16 writes (0x10-0x1F); auto-stop; length[1]=16; later ticks produce no mem_we.
5. In IDLE, rec_rise and play_rise in the same cycle with clip_sel=3 → RECORD on clip 3. Then rec_rise coincident with sample_tick → no write; IDLE; length[3]=0.
6. Reset pulled low mid-PLAY of clip 1 → playing, mem_re and audio_out = 0 without waiting for a clock edge; a subsequent play_rise on clip 1 does nothing (length cleared).

Source files
------------

// File: rtl/clip_controller.sv
// clip_controller: record/playback sequencer for a four-clip audio recorder.
// Each clip owns a fixed 2^OFFSET_W-sample region of the shared memory,
// addressed as {active_clip, offset}. Per-clip lengths bound playback.
//
// state  | meaning
// IDLE   | waiting for a record or play button press
// RECORD | writing one sample per sample_tick into the active clip
// PLAY   | reading one sample per sample_tick from the active clip
module clip_controller #(
  parameter int OFFSET_W = 16,
  parameter int DATA_W   = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  record,
  input  logic                  play,
  input  logic [1:0]            clip_sel,
  input  logic                  sample_tick,
  input  logic [DATA_W-1:0]     sample_in,
  output logic [OFFSET_W+1:0]   mem_addr,
  output logic                  mem_we,
  output logic [DATA_W-1:0]     mem_wdata,
  output logic                  mem_re,
  input  logic [DATA_W-1:0]     mem_rdata,
  output logic [DATA_W-1:0]     audio_out,
  output logic                  recording,
  output logic                  playing
);

  typedef enum logic [1:0] {S_IDLE, S_RECORD, S_PLAY} state_e;

  state_e                   state_q, state_d;
  logic [OFFSET_W-1:0]      offset_q, offset_d;
  logic [1:0]               clip_q, clip_d;
  logic [3:0][OFFSET_W:0]   len_q, len_d;
  logic                     record_q, play_q;
  logic [OFFSET_W+1:0]      addr_q, addr_d;
  logic                     we_q, we_d;
  logic [DATA_W-1:0]        wdata_q, wdata_d;
  logic                     re_q, re_d;
  logic                     rd_pend_q, rd_pend_d;
  logic [DATA_W-1:0]        audio_q, audio_d;

  logic                     rec_rise, play_rise;
  logic                     start_rec, start_play, do_write, do_read;
  logic                     offset_last;
  logic [OFFSET_W:0]        offset_inc;
  logic [OFFSET_W:0]        len_sel, len_act;

  assign rec_rise    = record & ~record_q;
  assign play_rise   = play & ~play_q;
  assign len_sel     = len_q[clip_sel];
  assign len_act     = len_q[clip_q];
  assign offset_last = (offset_q == '1);
  assign offset_inc  = {1'b0, offset_q} + 1'b1;

  // Stop requests win over a coincident sample_tick, so no access is issued.
  assign start_rec  = (state_q == S_IDLE) && rec_rise;
  assign start_play = (state_q == S_IDLE) && !rec_rise && play_rise && (len_sel != '0);
  assign do_write   = (state_q == S_RECORD) && sample_tick && !rec_rise;
  assign do_read    = (state_q == S_PLAY) && sample_tick && !play_rise;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: recording stops on button or full region, playback on
  // button or after the read of the last recorded sample
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (rec_rise)        state_d = S_RECORD;
        else if (start_play) state_d = S_PLAY;
      end
      S_RECORD: begin
        if (rec_rise)                     state_d = S_IDLE;
        else if (do_write && offset_last) state_d = S_IDLE;
      end
      S_PLAY: begin
        if (play_rise)                            state_d = S_IDLE;
        else if (do_read && offset_inc == len_act) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output/datapath logic: memory strobes, offset and length bookkeeping
  always_comb begin
    offset_d  = offset_q;
    clip_d    = clip_q;
    len_d     = len_q;
    addr_d    = addr_q;
    we_d      = 1'b0;
    wdata_d   = wdata_q;
    re_d      = 1'b0;
    rd_pend_d = re_q;
    audio_d   = rd_pend_q ? mem_rdata : audio_q;
    if (start_rec) begin
      clip_d          = clip_sel;
      offset_d        = '0;
      len_d[clip_sel] = '0;
    end
    if (start_play) begin
      clip_d   = clip_sel;
      offset_d = '0;
    end
    if (do_write) begin
      we_d          = 1'b1;
      addr_d        = {clip_q, offset_q};
      wdata_d       = sample_in;
      offset_d      = offset_q + 1'b1;
      len_d[clip_q] = offset_inc;
    end
    if (do_read) begin
      re_d     = 1'b1;
      addr_d   = {clip_q, offset_q};
      offset_d = offset_q + 1'b1;
    end
  end

  // Datapath registers; reset also wipes every clip length
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      offset_q  <= '0;
      clip_q    <= '0;
      len_q     <= '0;
      record_q  <= 1'b0;
      play_q    <= 1'b0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      wdata_q   <= '0;
      re_q      <= 1'b0;
      rd_pend_q <= 1'b0;
      audio_q   <= '0;
    end else begin
      offset_q  <= offset_d;
      clip_q    <= clip_d;
      len_q     <= len_d;
      record_q  <= record;
      play_q    <= play;
      addr_q    <= addr_d;
      we_q      <= we_d;
      wdata_q   <= wdata_d;
      re_q      <= re_d;
      rd_pend_q <= rd_pend_d;
      audio_q   <= audio_d;
    end
  end

  assign mem_addr  = addr_q;
  assign mem_we    = we_q;
  assign mem_wdata = wdata_q;
  assign mem_re    = re_q;
  assign audio_out = audio_q;
  assign recording = (state_q == S_RECORD);
  assign playing   = (state_q == S_PLAY);

endmodule

// File: tb/tb_clip_controller.sv
// Bench for clip_controller with a 4-bit offset (16-sample clips).
module tb_clip_controller;

  logic       clock, reset, record, play, sample_tick;
  logic [1:0] clip_sel;
  logic [7:0] sample_in, mem_wdata, mem_rdata, audio_out;
  logic [5:0] mem_addr;
  logic       mem_we, mem_re, recording, playing;

  clip_controller #(.OFFSET_W(4), .DATA_W(8)) dut (
    .clock(clock), .reset(reset), .record(record), .play(play),
    .clip_sel(clip_sel), .sample_tick(sample_tick), .sample_in(sample_in),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_re(mem_re), .mem_rdata(mem_rdata), .audio_out(audio_out),
    .recording(recording), .playing(playing)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // synchronous sample memory
  logic [7:0] mem [64];
  always @(posedge clock) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  typedef struct {
    logic       rec, ply;
    logic [1:0] sel;
    logic       tick;
    logic [7:0] din;
    logic       erec, eply;
    logic [1:0] op;     // 0 none, 1 write, 2 read
    logic [5:0] addr;
    logic [7:0] data;   // write data, or audio expected from a read
  } vec_t;

  typedef struct {
    logic [1:0] op;
    logic [5:0] addr;
    logic [7:0] data;
  } ev_t;

  vec_t       vecs[$];
  ev_t        mem_q[$];
  logic [7:0] aud_q[$];
  logic [1:0] re_hist;
  int         tests, failed;

  function automatic vec_t mk(logic r, logic p, logic [1:0] s, logic t, logic [7:0] d,
                              logic er, logic ep, logic [1:0] op, logic [5:0] a, logic [7:0] x);
    vec_t v;
    v.rec = r; v.ply = p; v.sel = s; v.tick = t; v.din = d;
    v.erec = er; v.eply = ep; v.op = op; v.addr = a; v.data = x;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(vec_t v);
    ev_t e;
    record = v.rec; play = v.ply; clip_sel = v.sel;
    sample_tick = v.tick; sample_in = v.din;
    if (v.op != 2'd0) begin
      e.op = v.op; e.addr = v.addr; e.data = v.data;
      mem_q.push_back(e);
      if (v.op == 2'd2) aud_q.push_back(v.data);
    end
    @(posedge clock);
    @(negedge clock);
    chk("recording", 32'(recording), 32'(v.erec));
    chk("playing", 32'(playing), 32'(v.eply));
    if (mem_we || mem_re) begin
      if (mem_q.size() == 0) begin
        tests++; failed++;
        $display("FAIL unexpected_mem_op: we=%0b re=%0b addr=%0h, expected no access",
                 mem_we, mem_re, mem_addr);
      end else begin
        e = mem_q.pop_front();
        chk("mem_op", 32'({mem_re, mem_we}), 32'(e.op));
        chk("mem_addr", 32'(mem_addr), 32'(e.addr));
        if (e.op == 2'd1) chk("mem_wdata", 32'(mem_wdata), 32'(e.data));
      end
    end
    if (mem_q.size() != 0) begin
      tests++; failed++;
      $display("FAIL missing_mem_op: got no access, expected op=%0d addr=%0h",
               mem_q[0].op, mem_q[0].addr);
      mem_q.delete();
    end
    if (re_hist[1]) begin
      if (aud_q.size() == 0) begin
        tests++; failed++;
        $display("FAIL audio_unexpected: got %0h, expected no pending read", audio_out);
      end else begin
        chk("audio_out", 32'(audio_out), 32'(aud_q.pop_front()));
      end
    end
    re_hist = {re_hist[0], mem_re};
  endtask

  initial begin
    tests = 0; failed = 0; re_hist = 2'b00;
    reset = 1'b0; record = 1'b0; play = 1'b0; clip_sel = 2'd0;
    sample_tick = 1'b0; sample_in = 8'h00;

    // idle play on empty clips
    vecs.push_back(mk(0,1,0,0,8'h00, 0,0, 0,6'h00,8'h00));
    vecs.push_back(mk(0,0,0,0,8'h00, 0,0, 0,6'h00,8'h00));
    vecs.push_back(mk(0,1,3,1,8'h00, 0,0, 0,6'h00,8'h00));
    vecs.push_back(mk(0,0,3,0,8'h00, 0,0, 0,6'h00,8'h00));
    // record five samples on clip 2
    vecs.push_back(mk(1,0,2,0,8'h00, 1,0, 0,6'h00,8'h00));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0,0,2,1,8'(8'h11 + i), 1,0, 1,6'(6'h20 + i),8'(8'h11 + i)));
    vecs.push_back(mk(0,1,1,0,8'h00, 1,0, 0,6'h00,8'h00));
    vecs.push_back(mk(1,0,1,0,8'h00, 0,0, 0,6'h00,8'h00));
    // play clip 2 with six ticks
    vecs.push_back(mk(0,1,2,0,8'h00, 0,1, 0,6'h00,8'h00));
    for (int i = 0; i < 5; i++)
      vecs.push_back(mk(0,0,2,1,8'h00, 0,(i < 4), 2,6'(6'h20 + i),8'(8'h11 + i)));
    vecs.push_back(mk(0,0,2,1,8'h00, 0,0, 0,6'h00,8'h00));
    vecs.push_back(mk(0,0,2,0,8'h00, 0,0, 0,6'h00,8'h00));
    vecs.push_back(mk(0,0,2,0,8'h00, 0,0, 0,6'h00,8'h00));
    // record and play together: record wins; stop coincident with tick
    vecs.push_back(mk(1,1,3,0,8'h00, 1,0, 0,6'h00,8'h00));
    vecs.push_back(mk(0,0,0,0,8'h00, 1,0, 0,6'h00,8'h00));
    vecs.push_back(mk(1,0,0,1,8'hAA, 0,0, 0,6'h00,8'h00));
    vecs.push_back(mk(0,1,3,0,8'h00, 0,0, 0,6'h00,8'h00));
    vecs.push_back(mk(0,0,3,0,8'h00, 0,0, 0,6'h00,8'h00));
    // play stop coincident with tick
    vecs.push_back(mk(0,1,2,0,8'h00, 0,1, 0,6'h00,8'h00));
    vecs.push_back(mk(0,0,2,1,8'h00, 0,1, 2,6'h20,8'h11));
    vecs.push_back(mk(0,1,2,1,8'h00, 0,0, 0,6'h00,8'h00));
    vecs.push_back(mk(0,0,2,0,8'h00, 0,0, 0,6'h00,8'h00));
    vecs.push_back(mk(0,0,2,0,8'h00, 0,0, 0,6'h00,8'h00));

    // reset state
    repeat (2) @(posedge clock);
    #1;
    chk("rst_mem_addr", 32'(mem_addr), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_mem_wdata", 32'(mem_wdata), 32'h0);
    chk("rst_mem_re", 32'(mem_re), 32'h0);
    chk("rst_audio_out", 32'(audio_out), 32'h0);
    chk("rst_recording", 32'(recording), 32'h0);
    chk("rst_playing", 32'(playing), 32'h0);
    @(negedge clock);
    reset = 1'b1;

    foreach (vecs[i]) apply(vecs[i]);

    // clip 1: 20 ticks fill the 16-sample region and auto-stop
    apply(mk(1,0,1,0,8'h00, 1,0, 0,6'h00,8'h00));
    for (int i = 0; i < 20; i++) begin
      if (i < 16) apply(mk(0,0,1,1,8'(8'h40 + i), (i < 15),0, 1,6'(6'h10 + i),8'(8'h40 + i)));
      else        apply(mk(0,0,1,1,8'(8'h40 + i), 0,0, 0,6'h00,8'h00));
    end
    // full-length playback proves length[1]=16
    apply(mk(0,1,1,0,8'h00, 0,1, 0,6'h00,8'h00));
    for (int i = 0; i < 17; i++) begin
      if (i < 16) apply(mk(0,0,1,1,8'h00, 0,(i < 15), 2,6'(6'h10 + i),8'(8'h40 + i)));
      else        apply(mk(0,0,1,1,8'h00, 0,0, 0,6'h00,8'h00));
    end
    apply(mk(0,0,1,0,8'h00, 0,0, 0,6'h00,8'h00));
    apply(mk(0,0,1,0,8'h00, 0,0, 0,6'h00,8'h00));

    // reset mid-play of clip 1
    apply(mk(0,1,1,0,8'h00, 0,1, 0,6'h00,8'h00));
    for (int i = 0; i < 3; i++)
      apply(mk(0,0,1,1,8'h00, 0,1, 2,6'(6'h10 + i),8'(8'h40 + i)));
    chk("pre_rst_mem_re", 32'(mem_re), 32'h1);
    chk("pre_rst_audio", 32'(audio_out), 32'h40);
    #2 reset = 1'b0;
    #1;
    chk("async_playing", 32'(playing), 32'h0);
    chk("async_mem_re", 32'(mem_re), 32'h0);
    chk("async_audio_out", 32'(audio_out), 32'h0);
    chk("async_mem_addr", 32'(mem_addr), 32'h0);
    @(negedge clock);
    reset = 1'b1;
    mem_q.delete(); aud_q.delete(); re_hist = 2'b00;
    apply(mk(0,1,1,0,8'h00, 0,0, 0,6'h00,8'h00));
    apply(mk(0,0,1,1,8'h00, 0,0, 0,6'h00,8'h00));
    apply(mk(0,0,1,0,8'h00, 0,0, 0,6'h00,8'h00));

    if (aud_q.size() != 0) begin
      tests++; failed++;
      $display("FAIL audio_missing: got %0d undelivered samples, expected 0", aud_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
